wb_port_arbiter: RTL
====================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter NBITS, default 32: register-file data width.
REQ-002 Parameter NREGBITS, default 5: register address width.
REQ-003 Parameter MAX_WAIT, default 4, legal range >=1: maximum number of cycles a debug request loses to the pipeline.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 i_clk  in  1  clock; all state updates on its rising edge.
REQ-006 i_reset  in  1  synchronous active-high reset.
REQ-007 i_wb_valid  in  1  pipeline WB stage holds a register write this cycle.
REQ-008 i_wb_MemToReg  in  1  selects the WB data source: 0 = ALU result, 1 = memory data.
REQ-009 i_wb_MemData  in  NBITS  load/LUI data from the MEM stage.
REQ-010 i_wb_ALU_result  in  NBITS  ALU result.
REQ-011 i_wb_rd  in  NREGBITS  pipeline destination register.
REQ-012 i_dbg_req  in  1  debug-unit write request; level signal, held until ack.
REQ-013 i_dbg_rd  in  NREGBITS  debug destination register.
REQ-014 i_dbg_data  in  NBITS  debug write data.
REQ-015 o_dbg_ack  out  1  one-cycle pulse: debug write performed or discarded.
REQ-016 o_stall  out  1  freezes the pipeline (IF–WB) for the current cycle.
REQ-017 o_rf_we  out  1  register-file write enable.
REQ-018 o_rf_addr  out  NREGBITS  register-file write address.
REQ-019 o_rf_data  out  NBITS  register-file write data.

Function
REQ-020 WB data SHALL be i_wb_ALU_result when i_wb_MemToReg=0, and i_wb_MemData when i_wb_MemToReg=1.
REQ-021 o_rf_we, o_rf_addr, o_rf_data and o_dbg_ack SHALL be registered; a grant in cycle N produces the write in cycle N+1.
REQ-022 The FSM SHALL have three states: IDLE, DBG_WAIT and DBG_FORCE; o_stall SHALL be 1 only in DBG_FORCE, decoded directly from the state.
REQ-023 IDLE, i_dbg_req=1 and i_wb_valid=0: the debug source SHALL be granted and the FSM SHALL stay in IDLE.
REQ-024 IDLE, both requests present: the pipeline SHALL be granted, the wait counter SHALL be set to 1, and the FSM SHALL move to DBG_WAIT.
REQ-025 IDLE, only i_wb_valid=1: the pipeline SHALL be granted.
REQ-026 DBG_WAIT, i_wb_valid=0: the debug source SHALL be granted, the counter cleared, and the FSM SHALL return to IDLE.
REQ-027 DBG_WAIT, i_wb_valid=1: the pipeline SHALL be granted and the counter incremented; when the incremented value equals MAX_WAIT, the FSM SHALL move to DBG_FORCE.
REQ-028 DBG_FORCE: the debug source SHALL be granted unconditionally, pipeline inputs SHALL be ignored, the counter cleared, and the FSM SHALL return to IDLE next cycle.
REQ-029 DBG_WAIT, i_dbg_req falling to 0: the FSM SHALL return to IDLE with the counter cleared; no ack is issued.
REQ-030 Any granted write to register 0 SHALL produce o_rf_we=0; a debug grant to register 0 SHALL still pulse o_dbg_ack.
REQ-031 With no grant, o_rf_we SHALL be 0 next cycle; o_rf_addr and o_rf_data SHALL hold their previous values.
REQ-032 o_dbg_ack SHALL be 1 exactly in the cycle after a debug grant; i_dbg_req sampled high in that ack cycle is a new request.
REQ-033 The counter SHALL be $clog2(MAX_WAIT+1) bits wide and SHALL never exceed MAX_WAIT.

Reset
REQ-034 On i_reset=1 at a clock edge: FSM=IDLE, counter=0, o_rf_we=0, o_rf_addr=0, o_rf_data=0, o_dbg_ack=0; o_stall therefore becomes 0.
REQ-035 Reset SHALL abort any pending debug request without ack; reset SHALL take priority over all grants in the same cycle.

Structure
REQ-036 FSM state encodings and the source-select constants (SRC_NONE, SRC_WB, SRC_DBG) SHALL be placed in a shared package/include file.
REQ-037 The WB source select SHALL reuse the existing memory-to-register mux as the single sub-module; the arbiter FSM and output registers SHALL be local.

Verification
REQ-038 Pipeline only: i_wb_valid=1, MemToReg=1, MemData=0xDEADBEEF, rd=8 -> next cycle we=1, addr=8, data=0xDEADBEEF, ack=0.
REQ-039 Debug only: dbg_req=1, rd=3, data=0x12345678 -> next cycle we=1, addr=3, data=0x12345678, ack=1, stall=0 throughout.
REQ-040 Contention, MAX_WAIT=4: wb_valid held 1 with dbg_req held -> 4 pipeline writes; then stall=1 for one cycle; then debug write and ack=1.
REQ-041 Contention broken by a bubble: both requests, then wb_valid=0 in cycle 2 -> debug granted in cycle 2, write in cycle 3, stall never asserted.
REQ-042 Register 0: pipeline rd=0, ALU=0xFFFFFFFF -> we=0; debug rd=0 -> we=0, ack=1.
REQ-043 Reset mid-operation: i_reset=1 in DBG_FORCE -> next cycle stall=0, we=0, ack=0, FSM=IDLE, counter=0.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the write-back port arbiter.
//   arb_state_t : arbiter FSM states (IDLE / DBG_WAIT / DBG_FORCE)
//   src_sel_t   : which source owns the register-file write port this cycle
//   cnt_width() : width of the wait counter for a given MAX_WAIT
package wb_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DBG_WAIT  = 2'd1,
    DBG_FORCE = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_DBG  = 2'd2
  } src_sel_t;

  // The counter must be able to hold MAX_WAIT itself.
  function automatic int cnt_width(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the pipeline WB stage / debug unit and the arbiter.
//   i_wb_*      : pipeline write-back request and data
//   i_dbg_*     : debug-unit write request and data
//   o_dbg_ack   : one-cycle pulse, debug write performed or discarded
//   o_stall     : pipeline freeze for the current cycle
//   o_rf_*      : registered register-file write port
//
// Handshake: i_dbg_req is a level request that the debug unit holds, with
// i_dbg_rd/i_dbg_data stable, until it sees o_dbg_ack=1. The ack arrives the
// cycle after the grant; a request still sampled high in the ack cycle is
// treated as a brand-new request. i_wb_valid has no back-pressure other than
// o_stall: when o_stall=1 the WB stage contents are ignored and must be
// presented again once the pipeline resumes.
interface wb_port_arbiter_if #(
  parameter int NBITS    = 32,
  parameter int NREGBITS = 5
) ();

  logic                i_wb_valid;
  logic                i_wb_MemToReg;
  logic [NBITS-1:0]    i_wb_MemData;
  logic [NBITS-1:0]    i_wb_ALU_result;
  logic [NREGBITS-1:0] i_wb_rd;
  logic                i_dbg_req;
  logic [NREGBITS-1:0] i_dbg_rd;
  logic [NBITS-1:0]    i_dbg_data;
  logic                o_dbg_ack;
  logic                o_stall;
  logic                o_rf_we;
  logic [NREGBITS-1:0] o_rf_addr;
  logic [NBITS-1:0]    o_rf_data;

  // Arbiter side.
  modport slave (
    input  i_wb_valid, i_wb_MemToReg, i_wb_MemData, i_wb_ALU_result, i_wb_rd,
    input  i_dbg_req, i_dbg_rd, i_dbg_data,
    output o_dbg_ack, o_stall, o_rf_we, o_rf_addr, o_rf_data
  );

  // Pipeline / debug-unit side.
  modport master (
    output i_wb_valid, i_wb_MemToReg, i_wb_MemData, i_wb_ALU_result, i_wb_rd,
    output i_dbg_req, i_dbg_rd, i_dbg_data,
    input  o_dbg_ack, o_stall, o_rf_we, o_rf_addr, o_rf_data
  );

endinterface

// File: rtl/wb_port_arbiter_wb_mux.sv
// Memory-to-register mux of the WB stage.
//   i_mem_to_reg : 0 = ALU result, 1 = memory (load/LUI) data
//   i_mem_data   : data from the MEM stage
//   i_alu_result : ALU result
//   o_wb_data    : selected write-back data
module wb_port_arbiter_wb_mux #(
  parameter int NBITS = 32
) (
  input  logic             i_mem_to_reg,
  input  logic [NBITS-1:0] i_mem_data,
  input  logic [NBITS-1:0] i_alu_result,
  output logic [NBITS-1:0] o_wb_data
);

  assign o_wb_data = i_mem_to_reg ? i_mem_data : i_alu_result;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the pipeline WB stage and a
// debug unit. The pipeline normally wins; a debug request that keeps losing
// is forced through after MAX_WAIT cycles by stalling the pipeline once.
//   i_clk, i_reset : clock, synchronous active-high reset
//   bus            : request/data inputs and registered write port (slave)
//   o_fsm_state    : current arbiter state, for observation
//   o_wait_cnt     : cycles the pending debug request has lost so far
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int  NBITS    = 32,
  parameter int  NREGBITS = 5,
  parameter int  MAX_WAIT = 4,
  localparam int CW       = cnt_width(MAX_WAIT)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  wb_port_arbiter_if.slave    bus,
  output arb_state_t          o_fsm_state,
  output logic [CW-1:0]       o_wait_cnt
);

  arb_state_t          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
  src_sel_t            src;
  logic [NBITS-1:0]    wb_data;
  logic                rf_we_q, ack_q;
  logic [NREGBITS-1:0] rf_addr_q;
  logic [NBITS-1:0]    rf_data_q;

  wb_port_arbiter_wb_mux #(.NBITS(NBITS)) u_wb_mux (
    .i_mem_to_reg (bus.i_wb_MemToReg),
    .i_mem_data   (bus.i_wb_MemData),
    .i_alu_result (bus.i_wb_ALU_result),
    .o_wb_data    (wb_data)
  );

  assign cnt_inc = cnt_q + CW'(1);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter and grant selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src     = SRC_NONE;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.i_dbg_req && !bus.i_wb_valid) begin
          src = SRC_DBG;
        end else if (bus.i_dbg_req && bus.i_wb_valid) begin
          src   = SRC_WB;
          cnt_d = CW'(1);
          // With MAX_WAIT=1 the first lost cycle already exhausts the budget.
          state_d = (MAX_WAIT == 1) ? DBG_FORCE : DBG_WAIT;
        end else if (bus.i_wb_valid) begin
          src = SRC_WB;
        end
      end
      DBG_WAIT: begin
        if (!bus.i_dbg_req) begin
          // Debug unit withdrew: drop the pending request silently.
          state_d = IDLE;
          cnt_d   = '0;
          if (bus.i_wb_valid) src = SRC_WB;
        end else if (!bus.i_wb_valid) begin
          src     = SRC_DBG;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          src   = SRC_WB;
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(MAX_WAIT)) state_d = DBG_FORCE;
        end
      end
      DBG_FORCE: begin
        // Pipeline is frozen this cycle, so its WB contents are ignored.
        src     = SRC_DBG;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore outputs decoded from the state.
  always_comb begin
    bus.o_stall = (state_q == DBG_FORCE);
    o_fsm_state = state_q;
    o_wait_cnt  = cnt_q;
  end

  // Registered write port. Writes to r0 are suppressed but still acked.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      ack_q     <= 1'b0;
    end else begin
      case (src)
        SRC_WB: begin
          rf_we_q   <= (bus.i_wb_rd != '0);
          rf_addr_q <= bus.i_wb_rd;
          rf_data_q <= wb_data;
          ack_q     <= 1'b0;
        end
        SRC_DBG: begin
          rf_we_q   <= (bus.i_dbg_rd != '0);
          rf_addr_q <= bus.i_dbg_rd;
          rf_data_q <= bus.i_dbg_data;
          ack_q     <= 1'b1;
        end
        default: begin
          rf_we_q <= 1'b0;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_rf_we   = rf_we_q;
  assign bus.o_rf_addr = rf_addr_q;
  assign bus.o_rf_data = rf_data_q;
  assign bus.o_dbg_ack = ack_q;

endmodule
